// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer:
// op encodings, FSM states, step modes and iteration count.
package hilo_muldiv_ctrl_pkg;

  localparam int ITER = 32;
  localparam int CW   = $clog2(ITER);

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  typedef enum logic {
    MODE_MUL,
    MODE_DIV
  } mode_t;

  // Magnitude of a two's complement value when sgn is set,
  // raw value otherwise.
  function automatic logic [31:0] mag32(
    input logic [31:0] v,
    input logic        sgn
  );
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/hilo_step.sv
// One iteration of the shift-add multiplier / restoring divider.
// Ports: mode, rem (acc upper / remainder), bits (multiplier /
// quotient), operand (multiplicand / divisor); rem_next, bits_next.
module hilo_step
  import hilo_muldiv_ctrl_pkg::*;
(
  input  mode_t       mode,
  input  logic [32:0] rem,
  input  logic [31:0] bits,
  input  logic [31:0] operand,
  output logic [32:0] rem_next,
  output logic [31:0] bits_next
);

  logic [32:0] sum;
  logic [32:0] shifted;
  logic [33:0] diff;

  always_comb begin
    sum       = '0;
    shifted   = '0;
    diff      = '0;
    rem_next  = rem;
    bits_next = bits;
    unique case (mode)
      MODE_MUL: begin
        // Add multiplicand when the current multiplier bit is set,
        // then shift the 65-bit {carry, acc, multiplier} right by one.
        sum = rem + (bits[0] ? {1'b0, operand} : 33'd0);
        rem_next  = {1'b0, sum[32:1]};
        bits_next = {sum[0], bits[31:1]};
      end
      MODE_DIV: begin
        // Partial remainder shifted left with the next dividend bit;
        // the dividend drains out of bits as quotient bits fill in.
        shifted = {rem[31:0], bits[31]};
        diff    = {1'b0, shifted} - {2'b00, operand};
        if (!diff[33]) begin
          rem_next  = diff[32:0];
          bits_next = {bits[30:0], 1'b1};
        end else begin
          rem_next  = shifted;
          bits_next = {bits[30:0], 1'b0};
        end
      end
      default: begin
        rem_next  = rem;
        bits_next = bits;
      end
    endcase
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, plus MTHI/MTLO.
// Ports: clock, reset_n, start, op, operador1/2 in; busy, done, div_zero, hi, lo out.
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] operador1,
  input  logic [31:0] operador2,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_t        state_q, state_d;
  mode_t         mode_q, mode_d;
  logic [CW-1:0] count_q, count_d;
  logic [32:0]   rem_q, rem_d;
  logic [31:0]   bits_q, bits_d;
  logic [31:0]   operand_q, operand_d;
  logic          neg_res_q, neg_res_d;
  logic          neg_rem_q, neg_rem_d;
  logic [31:0]   hi_d, lo_d;
  logic          dz_d;

  logic [32:0]   rem_nx;
  logic [31:0]   bits_nx;

  logic          is_mul;
  logic          is_div;
  logic          is_signed;
  logic          go_calc;
  logic          go_dz;
  logic          is_mthi;
  logic          is_mtlo;
  logic [31:0]   a_mag;
  logic [31:0]   b_mag;
  logic [63:0]   prod;
  logic [63:0]   prod_fix;
  logic [31:0]   quo_fix;
  logic [31:0]   rmd_fix;

  hilo_step u_step (
    .mode      (mode_q),
    .rem       (rem_q),
    .bits      (bits_q),
    .operand   (operand_q),
    .rem_next  (rem_nx),
    .bits_next (bits_nx)
  );

  assign is_mul    = (op == OP_MULTU) || (op == OP_MULT);
  assign is_div    = (op == OP_DIVU) || (op == OP_DIV);
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign go_calc   = is_mul || (is_div && (operador2 != '0));
  assign go_dz     = is_div && (operador2 == '0);
  assign is_mthi   = (op == OP_MTHI);
  assign is_mtlo   = (op == OP_MTLO);

  assign a_mag = mag32(operador1, is_signed);
  assign b_mag = mag32(operador2, is_signed);

  // Final-iteration results with sign fixup; the most negative
  // quotient wraps to itself, so 0x80000000 / -1 needs no trap.
  assign prod     = {rem_nx[31:0], bits_nx};
  assign prod_fix = neg_res_q ? -prod : prod;
  assign quo_fix  = neg_res_q ? -bits_nx : bits_nx;
  assign rmd_fix  = neg_rem_q ? -rem_nx[31:0] : rem_nx[31:0];

  assign busy = (state_q == CALC) || (state_q == DONE);
  assign done = (state_q == DONE);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    count_d   = count_q;
    rem_d     = rem_q;
    bits_d    = bits_q;
    operand_d = operand_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi;
    lo_d      = lo;
    dz_d      = div_zero;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          unique case (1'b1)
            go_calc: begin
              mode_d    = is_mul ? MODE_MUL : MODE_DIV;
              rem_d     = '0;
              bits_d    = a_mag;
              operand_d = b_mag;
              neg_res_d = is_signed &&
                          (operador1[31] ^ operador2[31]);
              neg_rem_d = is_signed && operador1[31];
              count_d   = CW'(ITER - 1);
              dz_d      = 1'b0;
              state_d   = CALC;
            end
            go_dz: begin
              hi_d    = operador1;
              lo_d    = '1;
              dz_d    = 1'b1;
              state_d = DONE;
            end
            is_mthi: hi_d = operador1;
            is_mtlo: lo_d = operador1;
            default: ;
          endcase
        end
      end
      CALC: begin
        rem_d  = rem_nx;
        bits_d = bits_nx;
        if (count_q == '0) begin
          if (mode_q == MODE_MUL) begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end else begin
            hi_d = rmd_fix;
            lo_d = quo_fix;
          end
          state_d = DONE;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      mode_q    <= MODE_MUL;
      count_q   <= '0;
      rem_q     <= '0;
      bits_q    <= '0;
      operand_q <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      div_zero  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      bits_q    <= bits_d;
      operand_q <= operand_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi        <= hi_d;
      lo        <= lo_d;
      div_zero  <= dz_d;
    end
  end

endmodule
